mem_loader: RTL and testbench
=============================

# mem_loader

Boot-time program loader that drives the write side of the unified program/data memory. It receives a framed byte stream over a valid/ready interface, assembles little-endian 16-bit words, and writes them sequentially into memory from `BASE_ADDR`. It holds the CPU in reset until a complete, checksum-verified image has been loaded.

## Interface
- `BASE_ADDR`, default 16'h0000: word address of the first write.
- `MAX_WORDS`, default 1024: largest accepted word count. This matches the memory depth.
- `clk` input, 1 bit: single clock. All state changes on the rising edge.
- `rst_n_i` input, 1 bit: asynchronous, active-low reset.
- `start_i` input, 1 bit: re-arms the loader from DONE or ERROR.
- `rx_data_i` input, 8 bits: incoming byte.
- `rx_valid_i` input, 1 bit: `rx_data_i` is valid.
- `rx_ready_o` output, 1 bit: the loader can accept a byte this cycle.
- `d_addr_o` output, 16 bits: memory data-port word address.
- `d_we_o` output, 1 bit: memory write enable, one-cycle pulse per word.
- `d_data_o` output, 16 bits: memory write data.
- `busy_o` output, 1 bit: a frame is in progress (past the sync byte).
- `done_o` output, 1 bit: the last frame loaded and verified.
- `error_o` output, 1 bit: the last frame was rejected.
- `cpu_hold_o` output, 1 bit: holds the CPU in reset. It is low only in DONE.

## Operation
- Frame format: sync byte 0xA5, then N_lo, N_hi, then 2N data bytes (low byte first for each word), then CSUM.
- N is the 16-bit word count.
- CSUM is the 8-bit sum, mod 256, of all 2N data bytes.
- A byte transfers on a rising edge where `rx_valid_i && rx_ready_o`.
- The state machine has these states: SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CSUM, DONE, ERROR.
- SYNC:
  - A byte equal to 0xA5 moves to LEN_LO.
  - Any other byte is consumed and discarded, and the state stays in SYNC.
- LEN_LO: latch N[7:0], then go to LEN_HI.
- LEN_HI:
  - Latch N[15:0] and clear the word index and the checksum accumulator.
  - If N==0 or N>MAX_WORDS, go to ERROR.
  - Otherwise go to DATA_LO.
- DATA_LO: latch the low byte, add it to the checksum, then go to DATA_HI.
- DATA_HI: latch the high byte, add it to the checksum, then go to WRITE.
- WRITE:
  - Lasts exactly one cycle with `d_we_o`=1, `d_addr_o`=BASE_ADDR+index (mod 2^16), and `d_data_o`={hi,lo}.
  - Then increment the index.
  - If index+1==N, go to CSUM. Otherwise go to DATA_LO.
- CSUM: if the received byte equals the accumulator, go to DONE. Otherwise go to ERROR.
  - On ERROR, words already written stay in memory.
- DONE and ERROR: hold their state. `start_i`=1 moves to SYNC.
- `start_i` is ignored in every other state.
- `rx_ready_o` is 1 in SYNC, LEN_LO, LEN_HI, DATA_LO, DATA_HI and CSUM. It is 0 in WRITE, DONE and ERROR.
- `busy_o` is 1 in LEN_LO through CSUM.
- `done_o` is 1 only in DONE. `error_o` is 1 only in ERROR.
- `cpu_hold_o` is 1 in every state except DONE.
- All outputs are registered or decoded directly from the state register. There is no combinational path from `rx_valid_i` to any output.
- Arithmetic widths:
  - The checksum accumulator is 8 bits and wraps.
  - The index and N are 16 bits.
  - Address addition wraps at 16 bits.

## Timing
- Reset values: state=SYNC, `d_we_o`=0, `d_addr_o`=BASE_ADDR, `d_data_o`=0, `busy_o`=0, `done_o`=0, `error_o`=0, `cpu_hold_o`=1.
- `rx_ready_o` is 0 while `rst_n_i` is low and 1 on the first cycle after release.
- Write latency: `d_we_o` is high in the cycle immediately after the edge that accepted the DATA_HI byte. The memory captures the write on the following edge.
- Throughput is one word per 3 cycles when `rx_valid_i` is held high.
- A byte offered during WRITE is not consumed. It must remain stable and is accepted in DATA_LO on the next cycle.
- Reset mid-frame:
  - Aborts immediately and returns to SYNC.
  - Any pending write is dropped (`d_we_o`=0 asynchronously).
  - Memory already written is not cleared.
- If `start_i` and a byte arrive together in DONE or ERROR, the byte is not consumed (`rx_ready_o`=0). Only the transition to SYNC occurs.

## Test plan
- Stream A5 02 00 34 12 78 56 14 -> exactly two writes: addr 0x0000=0x1234 and addr 0x0001=0x5678. Afterwards `done_o`=1 and `cpu_hold_o`=0.
- Stream 00 FF 3C, then the frame above -> the three leading bytes are consumed with no writes. The result is identical to the first scenario.
- Stream A5 00 00, and separately A5 01 04 (N=1025) -> no `d_we_o` pulse, `error_o`=1, `cpu_hold_o`=1.
- Stream A5 01 00 CD AB 00 (correct CSUM is 0x78) -> one write, addr 0=0xABCD, then `error_o`=1 and `cpu_hold_o`=1. Pulse `start_i` -> return to SYNC with `error_o`=0.
- First frame with `rx_valid_i` held high throughout -> `rx_ready_o`=0 exactly in each WRITE cycle, and no byte is lost or duplicated. The same frame with random valid gaps produces identical writes.
- Assert `rst_n_i` low after the first data word of a 2-word frame -> `d_we_o` drops immediately and the state returns to SYNC. A following full frame with BASE_ADDR=0x0100 loads at 0x0100 and 0x0101.

Source files
------------

// File: rtl/mem_loader.sv
// Boot-time program loader: receives a framed byte stream, writes little-endian
// 16-bit words into memory from BASE_ADDR, and holds the CPU until the image verifies.
module mem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [15:0] d_addr_o,
  output logic        d_we_o,
  output logic [15:0] d_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        cpu_hold_o
);

  typedef enum logic [3:0] {
    S_SYNC    = 4'd0,
    S_LEN_LO  = 4'd1,
    S_LEN_HI  = 4'd2,
    S_DATA_LO = 4'd3,
    S_DATA_HI = 4'd4,
    S_WRITE   = 4'd5,
    S_CSUM    = 4'd6,
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
  } state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [16:0] MAX_C     = 17'(MAX_WORDS);

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] n_r, idx_r, addr_r, data_r, n_next_s;
  logic [7:0]  lo_r, csum_r;
  logic        ready_r, we_r, busy_r, done_r, error_r, hold_r;
  logic        xfer_s, len_bad_s;

  // Ready is registered, so a byte transfers only against the registered handshake.
  assign xfer_s    = rx_valid_i && ready_r;
  assign n_next_s  = {rx_data_i, n_r[7:0]};
  assign len_bad_s = (n_next_s == 16'd0) || ({1'b0, n_next_s} > MAX_C);

  // Next-state decode of the frame parser.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_SYNC: begin
        if (xfer_s && (rx_data_i == SYNC_BYTE)) state_s = S_LEN_LO;
        else                                    state_s = S_SYNC;
      end
      S_LEN_LO: begin
        if (xfer_s) state_s = S_LEN_HI;
        else        state_s = S_LEN_LO;
      end
      S_LEN_HI: begin
        if (xfer_s) state_s = len_bad_s ? S_ERROR : S_DATA_LO;
        else        state_s = S_LEN_HI;
      end
      S_DATA_LO: begin
        if (xfer_s) state_s = S_DATA_HI;
        else        state_s = S_DATA_LO;
      end
      S_DATA_HI: begin
        if (xfer_s) state_s = S_WRITE;
        else        state_s = S_DATA_HI;
      end
      S_WRITE: begin
        if ((idx_r + 16'd1) == n_r) state_s = S_CSUM;
        else                        state_s = S_DATA_LO;
      end
      S_CSUM: begin
        if (xfer_s) state_s = (rx_data_i == csum_r) ? S_DONE : S_ERROR;
        else        state_s = S_CSUM;
      end
      S_DONE, S_ERROR: begin
        if (start_i) state_s = S_SYNC;
        else         state_s = state_r;
      end
      default: state_s = S_SYNC;
    endcase
  end

  // State register plus status flags registered from the next state, so they track state_r exactly.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= S_SYNC;
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      hold_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      ready_r <= state_s inside {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CSUM};
      we_r    <= (state_s == S_WRITE);
      busy_r  <= state_s inside {S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_WRITE, S_CSUM};
      done_r  <= (state_s == S_DONE);
      error_r <= (state_s == S_ERROR);
      hold_r  <= (state_s != S_DONE);
    end
  end

  // Length, word index, checksum and write-port datapath.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      n_r    <= 16'd0;
      idx_r  <= 16'd0;
      lo_r   <= 8'd0;
      csum_r <= 8'd0;
      addr_r <= BASE_ADDR;
      data_r <= 16'd0;
    end else begin
      case (state_r)
        S_LEN_LO: if (xfer_s) n_r[7:0] <= rx_data_i;
        S_LEN_HI: begin
          if (xfer_s) begin
            n_r    <= n_next_s;
            idx_r  <= 16'd0;
            csum_r <= 8'd0;
          end
        end
        S_DATA_LO: begin
          if (xfer_s) begin
            lo_r   <= rx_data_i;
            csum_r <= csum_add(csum_r, rx_data_i);
          end
        end
        S_DATA_HI: begin
          // Address and data are staged here so the WRITE cycle presents them from flops.
          if (xfer_s) begin
            data_r <= {rx_data_i, lo_r};
            addr_r <= BASE_ADDR + idx_r;
            csum_r <= csum_add(csum_r, rx_data_i);
          end
        end
        S_WRITE: idx_r <= idx_r + 16'd1;
        default: ;
      endcase
    end
  end

  assign rx_ready_o = ready_r;
  assign d_we_o     = we_r;
  assign d_addr_o   = addr_r;
  assign d_data_o   = data_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign error_o    = error_r;
  assign cpu_hold_o = hold_r;

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader; a second instance with BASE_ADDR=0x0100
// shares the stimulus to check address offsetting.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o, d_we_o, busy_o, done_o, error_o, cpu_hold_o;
  logic [15:0] d_addr_o, d_data_o;
  logic        b_ready, b_we, b_busy, b_done, b_error, b_hold;
  logic [15:0] b_addr, b_data;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt = 0;
  int stall_we_bad = 0;
  logic [15:0] wa_q[$], wd_q[$], ba_q[$], bd_q[$];

  mem_loader dut (
    .clk(clk), .rst_n_i(rst_n_i), .start_i(start_i), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .d_addr_o(d_addr_o),
    .d_we_o(d_we_o), .d_data_o(d_data_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .cpu_hold_o(cpu_hold_o)
  );

  mem_loader #(.BASE_ADDR(16'h0100), .MAX_WORDS(1024)) dut_b (
    .clk(clk), .rst_n_i(rst_n_i), .start_i(start_i), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .rx_ready_o(b_ready), .d_addr_o(b_addr),
    .d_we_o(b_we), .d_data_o(b_data), .busy_o(b_busy), .done_o(b_done),
    .error_o(b_error), .cpu_hold_o(b_hold)
  );

  always #5 clk = ~clk;

  // Write log: each WRITE lasts one cycle, so one negedge sample per word.
  always @(negedge clk) begin
    if (d_we_o) begin wa_q.push_back(d_addr_o); wd_q.push_back(d_data_o); end
    if (b_we)   begin ba_q.push_back(b_addr);   bd_q.push_back(b_data);   end
  end

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); ba_q.delete(); bd_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    int waited;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin @(negedge clk); rx_valid_i = 1'b0; end
    @(negedge clk);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    waited = 0;
    while (!rx_ready_o && waited < 20) begin
      stall_cnt++;
      if (!d_we_o) stall_we_bad++;
      @(negedge clk);
      waited++;
    end
    if (!rx_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_timeout byte=%h ready=%b required 1", b, rx_ready_o);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit gaps);
    foreach (bytes[i]) send_byte(bytes[i], gaps);
    @(negedge clk);
    rx_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (rx_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b want=0", rx_ready_o); end
    n_cmp++; if ({d_we_o, busy_o, done_o, error_o, cpu_hold_o} !== 5'b00001) begin n_bad++;
      $display("FAIL rst_flags got=%b want=00001", {d_we_o, busy_o, done_o, error_o, cpu_hold_o}); end
    n_cmp++; if (d_addr_o !== 16'h0000 || d_data_o !== 16'h0000) begin n_bad++;
      $display("FAIL rst_addr_data got=%h/%h want=0000/0000", d_addr_o, d_data_o); end
    n_cmp++; if (b_addr !== 16'h0100) begin n_bad++; $display("FAIL rst_base_b got=%h want=0100", b_addr); end
    @(negedge clk); rst_n_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (rx_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready got=%b want=1", rx_ready_o); end
  endtask

  task automatic test_basic(input bit gaps);
    logic [7:0] fr[$];
    fr = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
    clear_logs();
    stall_cnt = 0; stall_we_bad = 0;
    send_frame(fr, gaps);
    n_cmp++; if (wa_q.size() !== 2) begin n_bad++; $display("FAIL basic_wcount gaps=%0d got=%0d want=2", gaps, wa_q.size()); end
    else begin
      n_cmp++; if (wa_q[0] !== 16'h0000 || wd_q[0] !== 16'h1234) begin n_bad++;
        $display("FAIL basic_w0 got=%h=%h want=0000=1234", wa_q[0], wd_q[0]); end
      n_cmp++; if (wa_q[1] !== 16'h0001 || wd_q[1] !== 16'h5678) begin n_bad++;
        $display("FAIL basic_w1 got=%h=%h want=0001=5678", wa_q[1], wd_q[1]); end
    end
    n_cmp++; if ({done_o, error_o, cpu_hold_o, busy_o} !== 4'b1000) begin n_bad++;
      $display("FAIL basic_done got=%b want=1000", {done_o, error_o, cpu_hold_o, busy_o}); end
    if (!gaps) begin
      n_cmp++; if (stall_cnt !== 2 || stall_we_bad !== 0) begin n_bad++;
        $display("FAIL basic_stalls got=%0d/%0d want=2/0", stall_cnt, stall_we_bad); end
    end
    pulse_start();
    n_cmp++; if (done_o !== 1'b0 || cpu_hold_o !== 1'b1 || rx_ready_o !== 1'b1) begin n_bad++;
      $display("FAIL basic_restart got=%b%b%b want=011", done_o, cpu_hold_o, rx_ready_o); end
  endtask

  task automatic test_sync_garbage();
    logic [7:0] g3[$];
    g3 = '{8'h00, 8'hFF, 8'h3C};
    clear_logs();
    send_frame(g3, 1'b0);
    n_cmp++; if (busy_o !== 1'b0 || wa_q.size() !== 0) begin n_bad++;
      $display("FAIL garbage_idle busy=%b writes=%0d want 0/0", busy_o, wa_q.size()); end
    test_basic(1'b1);
  endtask

  task automatic test_len_error(input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] fr[$];
    fr = '{8'hA5, lo, hi};
    clear_logs();
    send_frame(fr, 1'b0);
    n_cmp++; if ({error_o, cpu_hold_o, done_o} !== 3'b110 || wa_q.size() !== 0) begin n_bad++;
      $display("FAIL len_err N=%h%h got=%b writes=%0d want=110/0", hi, lo, {error_o, cpu_hold_o, done_o}, wa_q.size()); end
    // start together with a byte: only the return to SYNC happens
    @(negedge clk); start_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 8'hA5;
    n_cmp++; if (rx_ready_o !== 1'b0) begin n_bad++; $display("FAIL start_ready got=%b want=0", rx_ready_o); end
    @(negedge clk); start_i = 1'b0; rx_valid_i = 1'b0;
    n_cmp++; if ({error_o, busy_o, rx_ready_o} !== 3'b001) begin n_bad++;
      $display("FAIL start_resync got=%b want=001", {error_o, busy_o, rx_ready_o}); end
  endtask

  task automatic test_csum_error();
    logic [7:0] fr[$];
    fr = '{8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB, 8'h00};
    clear_logs();
    send_frame(fr, 1'b0);
    n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL csum_wcount got=%0d want=1", wa_q.size()); end
    else begin
      n_cmp++; if (wa_q[0] !== 16'h0000 || wd_q[0] !== 16'hABCD) begin n_bad++;
        $display("FAIL csum_w0 got=%h=%h want=0000=abcd", wa_q[0], wd_q[0]); end
    end
    n_cmp++; if ({error_o, cpu_hold_o, done_o} !== 3'b110) begin n_bad++;
      $display("FAIL csum_err got=%b want=110", {error_o, cpu_hold_o, done_o}); end
    pulse_start();
    n_cmp++; if (error_o !== 1'b0 || rx_ready_o !== 1'b1) begin n_bad++;
      $display("FAIL csum_restart got=%b%b want=01", error_o, rx_ready_o); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] fr[$];
    clear_logs();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12};
    foreach (fr[i]) send_byte(fr[i], 1'b0);
    #2;
    n_cmp++; if (d_we_o !== 1'b1) begin n_bad++; $display("FAIL mid_we_pre got=%b want=1", d_we_o); end
    rst_n_i = 1'b0; rx_valid_i = 1'b0;
    #1;
    n_cmp++; if ({d_we_o, b_we, busy_o, rx_ready_o} !== 4'b0000) begin n_bad++;
      $display("FAIL mid_abort got=%b want=0000", {d_we_o, b_we, busy_o, rx_ready_o}); end
    @(negedge clk); rst_n_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (wa_q.size() !== 0 || rx_ready_o !== 1'b1) begin n_bad++;
      $display("FAIL mid_dropped writes=%0d ready=%b want 0/1", wa_q.size(), rx_ready_o); end
    fr = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
    send_frame(fr, 1'b0);
    n_cmp++; if (ba_q.size() !== 2) begin n_bad++; $display("FAIL base_wcount got=%0d want=2", ba_q.size()); end
    else begin
      n_cmp++; if (ba_q[0] !== 16'h0100 || bd_q[0] !== 16'h1234 || ba_q[1] !== 16'h0101 || bd_q[1] !== 16'h5678) begin
        n_bad++; $display("FAIL base_writes got=%h=%h %h=%h want=0100=1234 0101=5678", ba_q[0], bd_q[0], ba_q[1], bd_q[1]); end
    end
    n_cmp++; if (b_done !== 1'b1 || b_hold !== 1'b0) begin n_bad++;
      $display("FAIL base_done got=%b%b want=10", b_done, b_hold); end
  endtask

  initial begin
    test_reset();
    test_basic(1'b0);
    test_sync_garbage();
    test_len_error(8'h00, 8'h00);
    test_len_error(8'h01, 8'h04);
    test_csum_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
